// File: rtl/load_hazard_ctrl.sv
// Load-use hazard controller between ID and EX: bubbles/stalls behind a load, waits out a busy
// data memory, then pulses per-source WB-forward selects. Optional stall counter: LOAD_HAZARD_PERF_EN.
module load_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FLUSH,
    input  logic                      EX_LOAD,
    input  logic [REG_AW-1:0]         EX_RD,
    input  logic [NUM_SRC*REG_AW-1:0] ID_RS,
    input  logic [NUM_SRC-1:0]        ID_RS_USE,
    input  logic                      MEM_BUSY,
    output logic [NUM_SRC-1:0]        FRWD_WB,
    output logic                      BUBBLE,
    output logic                      STALL,
`ifdef LOAD_HAZARD_PERF_EN
    output logic [CNT_W-1:0]          STALL_CNT,
`endif
    output logic                      TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUBL = 2'd1,
        WAIT = 2'd2,
        FWD  = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [NUM_SRC-1:0]  mask_q, mask_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0]  frwd_q, frwd_d;
    logic                bubble_q, bubble_d;
    logic                stall_q, stall_d;
    logic                timeout_q, timeout_d;
    logic [NUM_SRC-1:0]  match;
    logic                haz;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match[i] = (ID_RS[i*REG_AW +: REG_AW] == EX_RD) & ID_RS_USE[i];
        end
        haz = EX_LOAD & (EX_RD != '0) & (|match);
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        frwd_d    = '0;
        bubble_d  = 1'b0;
        stall_d   = 1'b0;
        timeout_d = timeout_q;
        if (FLUSH) begin
            // Flush beats any hazard or memory wait; the timeout flag is deliberately kept.
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, FWD: begin
                    if (haz) begin
                        state_d  = BUBL;
                        bubble_d = 1'b1;
                        stall_d  = 1'b1;
                        mask_d   = match;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUBL: begin
                    if (MEM_BUSY) begin
                        state_d  = WAIT;
                        bubble_d = 1'b1;
                        stall_d  = 1'b1;
                        cnt_d    = WAIT_W'(1);
                        if (cnt_d == MAX_W) timeout_d = 1'b1;
                    end else begin
                        state_d = FWD;
                        frwd_d  = mask_q;
                    end
                end
                WAIT: begin
                    if (MEM_BUSY) begin
                        bubble_d = 1'b1;
                        stall_d  = 1'b1;
                        cnt_d    = (cnt_q == MAX_W) ? cnt_q : cnt_q + WAIT_W'(1);
                        if (cnt_d == MAX_W) timeout_d = 1'b1;
                    end else begin
                        state_d = FWD;
                        frwd_d  = mask_q;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef LOAD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles the registered STALL was high; saturates, survives flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CNT = stall_cnt_q;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            frwd_q    <= '0;
            bubble_q  <= 1'b0;
            stall_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            frwd_q    <= frwd_d;
            bubble_q  <= bubble_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign FRWD_WB = frwd_q;
    assign BUBBLE  = bubble_q;
    assign STALL   = stall_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Scoreboard bench for load_hazard_ctrl: expected {FRWD_WB, BUBBLE, STALL, TIMEOUT} vectors are
// queued as each cycle's stimulus is driven and compared after the following clock edge.
module tb_load_hazard_ctrl;
  logic       CLK;
  logic       RESET;
  logic       FLUSH;
  logic       EX_LOAD;
  logic [4:0] EX_RD;
  logic [9:0] ID_RS;
  logic [1:0] ID_RS_USE;
  logic       MEM_BUSY;
  logic [1:0] FRWD_WB;
  logic       BUBBLE;
  logic       STALL;
  logic       TIMEOUT;
`ifdef LOAD_HAZARD_PERF_EN
  logic [15:0] STALL_CNT;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  load_hazard_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .EX_LOAD   (EX_LOAD),
    .EX_RD     (EX_RD),
    .ID_RS     (ID_RS),
    .ID_RS_USE (ID_RS_USE),
    .MEM_BUSY  (MEM_BUSY),
    .FRWD_WB   (FRWD_WB),
    .BUBBLE    (BUBBLE),
    .STALL     (STALL),
`ifdef LOAD_HAZARD_PERF_EN
    .STALL_CNT (STALL_CNT),
`endif
    .TIMEOUT   (TIMEOUT)
  );

  // clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // drive one cycle, queue the expected post-edge outputs {frwd, bubble, stall, timeout}
  task automatic step(input string tag, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs2, input logic [4:0] rs1, input logic [1:0] use_m,
                      input logic busy, input logic fl, input logic [4:0] exp);
    logic [4:0] got;
    EX_LOAD   = ld;
    EX_RD     = rd;
    ID_RS     = {rs2, rs1};
    ID_RS_USE = use_m;
    MEM_BUSY  = busy;
    FLUSH     = fl;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    got = {FRWD_WB, BUBBLE, STALL, TIMEOUT};
    check_eq(tag, {27'd0, got}, {27'd0, exp_q.pop_front()});
  endtask

  task automatic idle(input string tag, input logic [4:0] exp);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, exp);
  endtask

  initial begin
    FLUSH = 0; EX_LOAD = 0; EX_RD = 0; ID_RS = 0; ID_RS_USE = 0; MEM_BUSY = 0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1 check_eq("reset_outputs", {27'd0, FRWD_WB, BUBBLE, STALL, TIMEOUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    check_eq("reset_held_outputs", {27'd0, FRWD_WB, BUBBLE, STALL, TIMEOUT}, 32'd0);

    // single load-use on rs1, no memory wait
    step("s1_bubl", 1'b1, 5'd5, 5'd7, 5'd5, 2'b11, 1'b0, 1'b0, 5'b00_1_1_0);
    step("s1_fwd",  1'b0, 5'd0, 5'd7, 5'd5, 2'b11, 1'b0, 1'b0, 5'b01_0_0_0);
    idle("s1_idle", 5'b00_0_0_0);

    // x0 never hazards; unused operand never hazards
    step("s2_x0",     1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 5'b00_0_0_0);
    step("s2_unused", 1'b1, 5'd3, 5'd0, 5'd3, 2'b10, 1'b0, 1'b0, 5'b00_0_0_0);
    idle("s2_idle", 5'b00_0_0_0);

    // both sources match, three busy cycles
    step("s3_bubl",  1'b1, 5'd9, 5'd9, 5'd9, 2'b11, 1'b0, 1'b0, 5'b00_1_1_0);
    step("s3_wait1", 1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 1'b1, 1'b0, 5'b00_1_1_0);
    step("s3_wait2", 1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 1'b1, 1'b0, 5'b00_1_1_0);
    step("s3_wait3", 1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 1'b1, 1'b0, 5'b00_1_1_0);
    step("s3_fwd",   1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 1'b0, 1'b0, 5'b11_0_0_0);
    idle("s3_idle", 5'b00_0_0_0);
`ifdef LOAD_HAZARD_PERF_EN
    check_eq("stall_cnt", {16'd0, STALL_CNT}, 32'd5);
`endif

    // random non-hazard traffic: operands unused or no load
    for (int i = 0; i < 8; i++) begin
      step("rand_nohaz", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'b00,
           1'($urandom_range(0, 1)), 1'b0, 5'b00_0_0_0);
      step("rand_noload", 1'b0, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 2'b11, 1'b0, 1'b0, 5'b00_0_0_0);
    end

    // back-to-back loads: hazard seen while in FWD re-enters BUBL
    step("b2b_bubl1", 1'b1, 5'd4, 5'd0, 5'd4, 2'b01, 1'b0, 1'b0, 5'b00_1_1_0);
    step("b2b_fwd1",  1'b0, 5'd0, 5'd0, 5'd4, 2'b01, 1'b0, 1'b0, 5'b01_0_0_0);
    step("b2b_bubl2", 1'b1, 5'd6, 5'd6, 5'd0, 2'b10, 1'b0, 1'b0, 5'b00_1_1_0);
    step("b2b_fwd2",  1'b0, 5'd0, 5'd6, 5'd0, 2'b10, 1'b0, 1'b0, 5'b10_0_0_0);
    idle("b2b_idle", 5'b00_0_0_0);

    // flush in the second WAIT cycle, and flush beating a fresh hazard
    step("fl_bubl",  1'b1, 5'd8, 5'd8, 5'd1, 2'b11, 1'b0, 1'b0, 5'b00_1_1_0);
    step("fl_wait1", 1'b0, 5'd0, 5'd8, 5'd1, 2'b11, 1'b1, 1'b0, 5'b00_1_1_0);
    step("fl_wait2", 1'b0, 5'd0, 5'd8, 5'd1, 2'b11, 1'b1, 1'b0, 5'b00_1_1_0);
    step("fl_abort", 1'b0, 5'd0, 5'd8, 5'd1, 2'b11, 1'b1, 1'b1, 5'b00_0_0_0);
    step("fl_haz",   1'b1, 5'd8, 5'd8, 5'd1, 2'b11, 1'b0, 1'b1, 5'b00_0_0_0);
    idle("fl_idle", 5'b00_0_0_0);

    // async reset in the middle of BUBL
    step("rst_bubl", 1'b1, 5'd2, 5'd0, 5'd2, 2'b01, 1'b0, 1'b0, 5'b00_1_1_0);
    #2 RESET = 1'b0;
    #1 check_eq("rst_async", {27'd0, FRWD_WB, BUBBLE, STALL, TIMEOUT}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    idle("rst_idle", 5'b00_0_0_0);

    // memory busy for 20 cycles: TIMEOUT rises when the counter reaches 15 and sticks
    step("to_bubl", 1'b1, 5'd9, 5'd0, 5'd9, 2'b01, 1'b0, 1'b0, 5'b00_1_1_0);
    for (int k = 1; k <= 20; k++) begin
      step("to_wait", 1'b0, 5'd0, 5'd0, 5'd9, 2'b01, 1'b1, 1'b0,
           {2'b00, 1'b1, 1'b1, (k >= 15) ? 1'b1 : 1'b0});
    end
    step("to_fwd", 1'b0, 5'd0, 5'd0, 5'd9, 2'b01, 1'b0, 1'b0, 5'b01_0_0_1);
    idle("to_idle", 5'b00_0_0_1);
    step("to_flush", 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'b00_0_0_1);
    RESET = 1'b0;
    #1 check_eq("to_reset_clear", {31'd0, TIMEOUT}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    idle("to_after_reset", 5'b00_0_0_0);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
